// File: rtl/noc_traffic_gen.sv
// noc_traffic_gen
// ---------------------------------------------------------------------------
// Packet injector for one mesh-NoC node. It drives a router's local write
// port, honours the router FIFO's full/almost_full backpressure, and offers
// four destination modes, run/stop control and stall statistics.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-high
//   start        : one-cycle pulse, begins a run (ignored while running)
//   enable       : injection slot grant
//   full         : router FIFO full
//   almost_full  : router FIFO has one slot left
//   mode         : 0 fixed, 1 round-robin, 2 random (LFSR), 3 broadcast
//   fixed_dest   : destination for mode 0
//   num_packets  : flit budget, 0 = unlimited
//   dataOut      : flit {seq, src, dest, 1'b1}
//   write        : flit valid
//   done         : budget exhausted
//   sent_count   : flits issued in this run
//   stall_count  : cycles blocked by backpressure (saturating)
// ---------------------------------------------------------------------------
module noc_traffic_gen #(
    parameter int          ID        = 0,
    parameter int          DATA_W    = 16,
    parameter int          ID_W      = 2,
    parameter int          NUM_NODES = 4,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              enable,
    input  logic              full,
    input  logic              almost_full,
    input  logic [1:0]        mode,
    input  logic [ID_W-1:0]   fixed_dest,
    input  logic [CNT_W-1:0]  num_packets,
    output logic [DATA_W-1:0] dataOut,
    output logic              write,
    output logic              done,
    output logic [CNT_W-1:0]  sent_count,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int SEQ_W = DATA_W - 2*ID_W - 1;

    // Node-index arithmetic is done one bit wider so NUM_NODES = 2^ID_W fits.
    localparam logic [ID_W:0]   NODES      = (ID_W+1)'(NUM_NODES);
    localparam logic [ID_W:0]   ONE_X      = (ID_W+1)'(1);
    localparam logic [ID_W-1:0] SELF       = ID_W'(ID);
    localparam logic [ID_W-1:0] RR_INIT    = ID_W'((ID + 1) % NUM_NODES);
    // Lowest and highest node other than ourselves: broadcast group bounds.
    localparam logic [ID_W-1:0] FIRST_PEER = (ID == 0) ? ID_W'(1) : ID_W'(0);
    localparam logic [ID_W-1:0] LAST_PEER  = (ID == NUM_NODES-1) ? ID_W'(NUM_NODES-2)
                                                                 : ID_W'(NUM_NODES-1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg;
    logic [1:0]         mode_reg;
    logic [ID_W-1:0]    fixed_dest_reg;
    logic [CNT_W-1:0]   budget_reg;
    logic [SEQ_W-1:0]   seq_reg;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    bc_ptr_reg;
    logic [15:0]        lfsr_reg;

    logic               blocked;
    logic               issue;
    logic [ID_W-1:0]    dest_sel;
    logic [15:0]        lfsr_next;
    logic [CNT_W-1:0]   sent_next;

    // Next node modulo NUM_NODES.
    function automatic logic [ID_W-1:0] succ(input logic [ID_W-1:0] n);
        logic [ID_W:0] t;
        t = {1'b0, n} + ONE_X;
        if (t >= NODES)
            t = '0;
        return t[ID_W-1:0];
    endfunction

    // Next node modulo NUM_NODES, never landing on ourselves.
    function automatic logic [ID_W-1:0] peer_succ(input logic [ID_W-1:0] n);
        logic [ID_W-1:0] s;
        s = succ(n);
        if (s == SELF)
            s = succ(s);
        return s;
    endfunction

    // Fold the LFSR low bits into range (one subtraction suffices because
    // NUM_NODES > 2^(ID_W-1)), then steer self-addressing to the next node.
    function automatic logic [ID_W-1:0] rand_dest(input logic [ID_W-1:0] v);
        logic [ID_W:0]   ext;
        logic [ID_W-1:0] d;
        ext = {1'b0, v};
        if (ext >= NODES)
            ext = ext - NODES;
        d = ext[ID_W-1:0];
        if (d == SELF)
            d = RR_INIT;
        return d;
    endfunction

    always_comb begin
        // The FIFO flags lag by one cycle, so a flit already on the wire
        // must be counted against the last free slot.
        blocked   = (write & almost_full) | (~write & full);
        issue     = (state_reg == RUN) & enable & ~blocked;
        lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        sent_next = sent_count + CNT_W'(1);
        dest_sel  = fixed_dest_reg;
        case (mode_reg)
            2'd1:    dest_sel = rr_ptr_reg;
            2'd2:    dest_sel = rand_dest(lfsr_reg[ID_W-1:0]);
            2'd3:    dest_sel = bc_ptr_reg;
            default: dest_sel = fixed_dest_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            mode_reg       <= '0;
            fixed_dest_reg <= '0;
            budget_reg     <= '0;
            seq_reg        <= '0;
            rr_ptr_reg     <= RR_INIT;
            bc_ptr_reg     <= FIRST_PEER;
            lfsr_reg       <= LFSR_SEED;
            dataOut        <= '0;
            write          <= 1'b0;
            done           <= 1'b0;
            sent_count     <= '0;
            stall_count    <= '0;
        end else begin
            write <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg      <= RUN;
                        mode_reg       <= mode;
                        fixed_dest_reg <= fixed_dest;
                        budget_reg     <= num_packets;
                        seq_reg        <= '0;
                        sent_count     <= '0;
                        stall_count    <= '0;
                        done           <= 1'b0;
                        rr_ptr_reg     <= RR_INIT;
                        bc_ptr_reg     <= FIRST_PEER;
                    end
                end
                RUN: begin
                    if (enable && blocked && (stall_count != '1))
                        stall_count <= stall_count + CNT_W'(1);
                    if (issue) begin
                        dataOut    <= {seq_reg, SELF, dest_sel, 1'b1};
                        write      <= 1'b1;
                        sent_count <= sent_next;
                        case (mode_reg)
                            2'd1: begin
                                rr_ptr_reg <= peer_succ(rr_ptr_reg);
                                seq_reg    <= seq_reg + SEQ_W'(1);
                            end
                            2'd2: begin
                                lfsr_reg <= lfsr_next;
                                seq_reg  <= seq_reg + SEQ_W'(1);
                            end
                            2'd3: begin
                                // A broadcast group shares one seq number.
                                if (bc_ptr_reg == LAST_PEER) begin
                                    bc_ptr_reg <= FIRST_PEER;
                                    seq_reg    <= seq_reg + SEQ_W'(1);
                                end else begin
                                    bc_ptr_reg <= peer_succ(bc_ptr_reg);
                                end
                            end
                            default: seq_reg <= seq_reg + SEQ_W'(1);
                        endcase
                        if ((budget_reg != '0) && (sent_next == budget_reg)) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/noc_traffic_gen.md
# noc_traffic_gen

Parametrised packet injector for the mesh NoC, one instance per node; it drives a router's local write port and obeys that port's `full`/`almost_full` backpressure. It generalises the fixed-destination CPU stub: node count, data width and packet budget are configurable, and it has run/stop control, four destination modes and stall statistics. It sits between the testbench or compute tile and the router input FIFO.

## Interface
- `ID`, 0: this node's index, < `NUM_NODES`.
- `DATA_W`, 16: flit width.
- `ID_W`, 2: node-id field width.
- `NUM_NODES`, 4: node count. Constraint: 2^(ID_W-1) < `NUM_NODES` ≤ 2^ID_W.
- `CNT_W`, 16: width of the packet budget and the statistics counters.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse that begins a run.
- `enable` in 1: injection slot grant (e.g. a TDMA slot).
- `full` in 1: router FIFO full.
- `almost_full` in 1: router FIFO has one slot left.
- `mode` in 2: destination mode, sampled at `start`.
- `fixed_dest` in ID_W: destination for mode 0, sampled at `start`.
- `num_packets` in CNT_W: packet budget, sampled at `start`. 0 means unlimited.
- `dataOut` out DATA_W: flit.
- `write` out 1: flit valid.
- `done` out 1: budget exhausted.
- `sent_count` out CNT_W: packets issued.
- `stall_count` out CNT_W: cycles blocked by backpressure, saturating.

## Operation
- Flit format: {seq[SEQ_W-1:0], src=ID, dest, 1'b1}, where SEQ_W = DATA_W-2*ID_W-1 (11 bits at defaults). `seq` wraps modulo 2^SEQ_W.
- FSM states:
  - IDLE: on `start`, go to RUN.
  - RUN: when the budget is reached, go to DONE.
  - DONE: on `start`, go to RUN.
- `start` is ignored while in RUN.
- Entering RUN:
  - Latch `mode`, `fixed_dest` and `num_packets`.
  - Clear `seq`, `sent_count` and `stall_count`.
  - Clear `done`.
  - Initialise the round-robin pointer to (ID+1) mod NUM_NODES.
- `blocked` = (write & almost_full) | (~write & full).
- `issue` = RUN & enable & ~blocked.
- On `issue`:
  - Register the flit and set `write`=1.
  - Increment `seq` and `sent_count`.
  - Advance the mode state.
- Otherwise `write`=0 and `dataOut` holds its last value.
- `stall_count` increments on every cycle with RUN & enable & blocked, saturating at all-ones.
- Mode 0 (fixed): dest = latched `fixed_dest`. Self-addressing is allowed.
- Mode 1 (round-robin): dest = pointer. The pointer advances to the next node modulo NUM_NODES and skips ID.
- Mode 2 (random): a 16-bit Fibonacci LFSR with taps 16,14,13,11 steps once per issue.
  - Take v = lfsr[ID_W-1:0]; if v ≥ NUM_NODES, use v-NUM_NODES.
  - If the result equals ID, use (ID+1) mod NUM_NODES.
  - The LFSR resets to `LFSR_SEED` and is not reseeded at `start`.
- Mode 3 (broadcast): each logical packet goes to every node except ID, in ascending order, one flit per issue.
  - All flits of a group carry the same `seq`.
  - `seq` increments only after the last flit of the group.
  - `sent_count` counts flits.
- Budget: when an issue makes `sent_count` equal the latched `num_packets` (nonzero), the FSM moves to DONE at that same edge and `done` rises together with that last `write`.
- DONE: no further writes. `done` holds until `start` or `reset`.

## Timing
- Reset values: `dataOut`=0, `write`=0, `done`=0, `sent_count`=0, `stall_count`=0. The FSM is in IDLE, `seq`=0 and the LFSR holds the seed.
- All outputs are registered.
- `write` appears one cycle after the edge where `issue` is true.
- First possible `write`: the edge after `start` is sampled, plus one cycle.
- Maximum rate: one flit per cycle while `enable`=1 and `almost_full`=0.
- Once `almost_full` is seen with `write`=1, the next cycle issues nothing. This guarantees no overflow given the FIFO's one-cycle flag latency.
- `reset` asserted mid-run clears everything immediately. An in-flight `write` drops without waiting for a clock.
- `start` coincident with `reset`: reset wins.
- `sent_count` wraps at 2^CNT_W only in unlimited mode.

## Test plan
- Mode 0, ID=0, fixed_dest=3, num_packets=5, enable=1, no backpressure -> five consecutive writes with dataOut = 16'h0007, 16'h0027, 16'h0047, 16'h0067, 16'h0087. `done` rises with the fifth write; sent_count=5.
- Mode 1, ID=1, NUM_NODES=4 -> dest sequence 2, 3, 0, 2, 3, 0; ID 1 never appears.
- Mode 3, ID=2, num_packets=6 -> dests 0, 1, 3, 0, 1, 3 with seq 0, 0, 0, 1, 1, 1; done after the sixth flit.
- Backpressure: almost_full raised while write=1 -> write=0 on the next cycle. Then full held for 4 cycles with enable=1 -> no writes and stall_count=5. Flits resume in order with seq continuous and none dropped.
- Enable rotating 1-of-4 cycles -> writes appear only in cycles following enable; reset asserted mid-run -> all outputs 0 immediately and state returns to IDLE. A subsequent `start` restarts with seq=0.
- Mode 2, ID=0, four instances with the same seed -> dest never equals ID and is always < NUM_NODES. Sequence matches the reference LFSR model for 100 packets.
